// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an 8-bit FIFO one byte at a time and serialises each byte
// as start(0), 8 data bits LSB first, [even parity], stop(1); CLKS_PER_BIT clocks per bit.
// Optional feature macro: PARITY_EN (inserts an even-parity bit between data and stop).
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       empty,
    input  logic [7:0] fifo_data,
    output logic       remove,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BIT_W  = 3;

`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    baud_cnt, baud_nxt;
    logic [BIT_W-1:0]    bit_cnt, bit_nxt;
    logic [DATA_W-1:0]   shift_reg, shift_nxt;
    logic                tx_nxt, busy_nxt;
    logic                baud_wrap;
`ifdef PARITY_EN
    logic                parity, parity_nxt;
`endif

    assign baud_wrap = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // State, counters, shift register and registered line outputs
    always_ff @(posedge ck) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
`ifdef PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
            tx        <= tx_nxt;
            busy      <= busy_nxt;
`ifdef PARITY_EN
            parity    <= parity_nxt;
`endif
        end
    end

    // Next-state, next-output and pop strobe; every advance happens on a baud wrap
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        tx_nxt    = tx;
        busy_nxt  = busy;
`ifdef PARITY_EN
        parity_nxt = parity;
`endif
        remove    = (state == IDLE) & ~empty & ~reset;
        baud_nxt  = (state == IDLE || baud_wrap) ? '0 : baud_cnt + CNT_W'(1);

        case (state)
            IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (remove) begin
                    state_nxt = START;
                    shift_nxt = fifo_data;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
`ifdef PARITY_EN
                    parity_nxt = ^fifo_data;
`endif
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                    tx_nxt    = shift_reg[0];
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    if (bit_cnt == BIT_W'(DATA_W - 1)) begin
`ifdef PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = parity;
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        bit_nxt   = bit_cnt + BIT_W'(1);
                        shift_nxt = shift_reg >> 1;
                        tx_nxt    = shift_reg[1];
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (baud_wrap) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_wrap) begin
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: random FIFO traffic against a frame-level reference model.
// The predictor turns each expected pop into the list of line levels the frame must
// produce; the monitor pops one level per cycle and compares tx, busy and remove.
module tb_fifo_uart_tx;

    localparam int unsigned N = 4;
`ifdef PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    logic       ck;
    logic       reset;
    logic       empty;
    logic [7:0] fifo_data;
    logic       remove;
    logic       tx;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;
    int pops = 0;
    int last_pop = -1;
    int cycle = 0;
    bit chk_en = 0;
    bit prev_pop = 0;

    logic exp_q[$];

    fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .ck(ck),
        .reset(reset),
        .empty(empty),
        .fifo_data(fifo_data),
        .remove(remove),
        .tx(tx),
        .busy(busy)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cycle, act, exp);
        end
    endtask

    // Reference model and monitor, evaluated mid-cycle
    always @(negedge ck) begin
        logic exp_rm, exp_tx, exp_busy;
        logic [7:0] d;
        cycle++;
        if (chk_en) begin
            exp_rm = (exp_q.size() == 0) && !empty && !reset;
            check("remove", remove, exp_rm);
            if (exp_q.size() > 0) begin
                exp_tx   = exp_q.pop_front();
                exp_busy = 1'b1;
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end
            check("tx", tx, exp_tx);
            check("busy", busy, exp_busy);
            if (reset) begin
                exp_q.delete();
                prev_pop = 0;
            end else if (exp_rm) begin
                // Back-to-back frames must be exactly one frame plus one idle cycle apart
                if (prev_pop && cycle - last_pop <= int'(FRAME_BITS * N + 1))
                    check("pop_spacing", 1'b1, (cycle - last_pop) == int'(FRAME_BITS * N + 1));
                last_pop = cycle;
                prev_pop = 1;
                pops++;
                d = fifo_data;
                for (int b = 0; b < int'(FRAME_BITS); b++) begin
                    logic lvl;
                    if (b == 0) lvl = 1'b0;
                    else if (b <= 8) lvl = d[b-1];
                    else if (b == 9 && FRAME_BITS == 11) lvl = ^d;
                    else lvl = 1'b1;
                    for (int k = 0; k < int'(N); k++) exp_q.push_back(lvl);
                end
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic [7:0] d);
        @(posedge ck);
        #1;
        reset = r;
        empty = e;
        fifo_data = d;
    endtask

    initial begin
        reset = 1'b1;
        empty = 1'b0;
        fifo_data = 8'hA5;
        @(posedge ck);
        #1 chk_en = 1;
        @(posedge ck);
        #1 reset = 1'b0;

        // A5 frame, then 01 and 02 back to back with empty held low
        repeat (FRAME_BITS * N) step(1'b0, 1'b0, 8'h01);
        repeat (FRAME_BITS * N + 1) step(1'b0, 1'b0, 8'h02);
        repeat (FRAME_BITS * N) step(1'b0, 1'b1, 8'h00);
`ifdef PARITY_EN
        step(1'b0, 1'b0, 8'h07);
        repeat (FRAME_BITS * N + 2) step(1'b0, 1'b1, 8'h00);
`endif

        // Random traffic with occasional flushes and mid-frame resets
        for (int i = 0; i < 2500; i++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, 8'($urandom));

        // Idle line with an empty FIFO
        repeat (200) step(1'b0, 1'b1, 8'($urandom));

        // Reset during data bit 3 of an FF frame, FIFO empty afterwards
        step(1'b0, 1'b0, 8'hFF);
        step(1'b0, 1'b1, 8'h00);
        repeat (N + 3 * N + 1) step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h00);
        repeat (30) step(1'b0, 1'b1, 8'h00);

        @(negedge ck);
        tests_run++;
        if (pops < 20) begin
            tests_failed++;
            $display("FAIL pop_count: got %0d expected at least 20", pops);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
